// File: rtl/fp16_pkg.sv
// fp16_pkg: shared constants and types for the fp16 arithmetic units
// (squarer and square-root).
//   FP16_* field widths, bias, quiet-NaN bit and +INF encoding
//   fp16_t      sign/exponent/mantissa view of a half-precision word
//   fp16_state_e  sequencer states shared by the iterative units
package fp16_pkg;

   localparam int FP16_MANT_W = 10;
   localparam int FP16_EXP_W  = 5;
   localparam int FP16_BIAS   = 15;

   localparam logic [15:0] FP16_QNAN_BIT = 16'h0200;
   localparam logic [15:0] FP16_PINF     = 16'h7C00;

   typedef struct packed {
      logic       sign;
      logic [4:0] exp;
      logic [9:0] mant;
   } fp16_t;

   typedef enum logic [1:0] {
      LOAD = 2'd0,
      MULT = 2'd1,
      NORM = 2'd2,
      DONE = 2'd3
   } fp16_state_e;

endpackage

// File: rtl/fp16_mant_mul11.sv
// fp16_mant_mul11: sequential 11x11 shift-add multiplier, one partial
// product per clock.
//   clk_i    clock
//   rst_ni   synchronous active-low reset
//   start_i  latch m_i, clear the accumulator, begin 11 add steps
//   m_i      11-bit significand operand (squared)
//   prod_o   22-bit accumulator / product
//   last_o   high during the final step; prod_o is complete next cycle
module fp16_mant_mul11 (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        start_i,
   input  logic [10:0] m_i,
   output logic [21:0] prod_o,
   output logic        last_o
);

   logic [10:0] m_q,    m_d;
   logic [21:0] acc_q,  acc_d;
   logic [3:0]  cnt_q,  cnt_d;
   logic        busy_q, busy_d;

   always_comb begin
      m_d    = m_q;
      acc_d  = acc_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      if (start_i) begin
         m_d    = m_i;
         acc_d  = '0;
         cnt_d  = '0;
         busy_d = 1'b1;
      end else if (busy_q) begin
         // Multiplicand and multiplier are the same value (squaring).
         if (m_q[cnt_q])
            acc_d = acc_q + ({11'b0, m_q} << cnt_q);
         if (cnt_q == 4'd10) begin
            busy_d = 1'b0;
            cnt_d  = '0;
         end else begin
            cnt_d = cnt_q + 4'd1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         m_q    <= '0;
         acc_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else begin
         m_q    <= m_d;
         acc_q  <= acc_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
      end
   end

   assign prod_o = acc_q;
   assign last_o = busy_q && (cnt_q == 4'd10);

endmodule

// File: rtl/fp16_square.sv
// fp16_square: iterative IEEE-754 half-precision squarer, OUT = IN * IN,
// truncating rounding. Specials finish one edge after start, finite
// non-zero operands after 13 edges (LOAD, 11x MULT, NORM).
//   CLK       clock
//   ENABLE    synchronous active-low reset; high = run
//   IN_DATA   operand, captured on the first edge with ENABLE high
//   OUT_DATA  result, qualified by RESULT (0 otherwise)
//   RESULT    result valid; held until ENABLE drops
//   IS_NAN / IS_PINF / IS_NINF  result class flags (NINF is never set)
module fp16_square
   import fp16_pkg::*;
#(
   parameter int MANT_W = FP16_MANT_W,
   parameter int EXP_W  = FP16_EXP_W,
   parameter int BIAS   = FP16_BIAS
) (
   input  logic                    CLK,
   input  logic                    ENABLE,
   input  logic [MANT_W+EXP_W:0]   IN_DATA,
   output logic [MANT_W+EXP_W:0]   OUT_DATA,
   output logic                    RESULT,
   output logic                    IS_NAN,
   output logic                    IS_PINF,
   output logic                    IS_NINF
);

   fp16_state_e        state_q,  state_d;
   logic [15:0]        out_q,    out_d;
   logic               result_q, result_d;
   logic               nan_q,    nan_d;
   logic               pinf_q,   pinf_d;
   logic signed [6:0]  e_q,      e_d;

   fp16_t              op;
   logic [10:0]        norm_m;
   logic signed [6:0]  norm_e;
   logic [3:0]         lead;
   logic [3:0]         sh;

   logic               mul_start;
   logic [21:0]        mul_prod;
   logic               mul_last;

   logic [9:0]         frac;
   logic signed [7:0]  exp2;
   logic signed [7:0]  b;
   logic [7:0]         sub_sh;
   logic [10:0]        sig;
   logic               unused_lsbs;

   assign op = fp16_t'(IN_DATA);

   // Operand normalisation: subnormals are shifted until the hidden-bit
   // position is set, with the exponent lowered by the shift count.
   always_comb begin
      lead = '0;
      for (int i = 0; i < MANT_W; i++)
         if (op.mant[i]) lead = 4'(i);
      sh = 4'(MANT_W) - lead;
      if (op.exp != '0) begin
         norm_m = {1'b1, op.mant};
         norm_e = $signed({2'b00, op.exp}) - 7'(BIAS);
      end else begin
         norm_m = {1'b0, op.mant} << sh;
         norm_e = -7'sd14 - $signed({3'b000, sh});
      end
   end

   fp16_mant_mul11 u_mul (
      .clk_i   (CLK),
      .rst_ni  (ENABLE),
      .start_i (mul_start),
      .m_i     (norm_m),
      .prod_o  (mul_prod),
      .last_o  (mul_last)
   );

   // Product lies in [2^20, 2^22); bit 21 selects a one-place renormalise.
   // {e,1} / {e,0} is 2e+1 / 2e in two's complement.
   always_comb begin
      if (mul_prod[21]) begin
         frac = mul_prod[20:11];
         exp2 = {e_q, 1'b1};
      end else begin
         frac = mul_prod[19:10];
         exp2 = {e_q, 1'b0};
      end
      b      = exp2 + 8'(BIAS);
      sub_sh = 8'sd1 - b;
      sig    = {1'b1, frac} >> sub_sh;
   end

   // Bits below the kept fraction are dropped by truncation.
   assign unused_lsbs = ^mul_prod[9:0];

   always_comb begin
      state_d   = state_q;
      out_d     = out_q;
      result_d  = result_q;
      nan_d     = nan_q;
      pinf_d    = pinf_q;
      e_d       = e_q;
      mul_start = 1'b0;
      case (state_q)
         LOAD: begin
            if (op.exp == '1) begin
               if (op.mant != '0) begin
                  out_d = op | FP16_QNAN_BIT;
                  nan_d = 1'b1;
               end else begin
                  out_d  = FP16_PINF;
                  pinf_d = 1'b1;
               end
               result_d = 1'b1;
               state_d  = DONE;
            end else if (op.exp == '0 && op.mant == '0) begin
               out_d    = '0;
               result_d = 1'b1;
               state_d  = DONE;
            end else begin
               mul_start = 1'b1;
               e_d       = norm_e;
               state_d   = MULT;
            end
         end
         MULT: begin
            if (mul_last) state_d = NORM;
         end
         NORM: begin
            if (b >= 8'sd31) begin
               out_d  = FP16_PINF;
               pinf_d = 1'b1;
            end else if (b >= 8'sd1) begin
               out_d = {1'b0, b[4:0], frac};
            end else if (sub_sh > 8'd10) begin
               out_d = '0;
            end else begin
               out_d = {6'b0, sig[9:0]};
            end
            result_d = 1'b1;
            state_d  = DONE;
         end
         DONE: ;
         default: state_d = LOAD;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!ENABLE) begin
         state_q  <= LOAD;
         out_q    <= '0;
         result_q <= 1'b0;
         nan_q    <= 1'b0;
         pinf_q   <= 1'b0;
         e_q      <= '0;
      end else begin
         state_q  <= state_d;
         out_q    <= out_d;
         result_q <= result_d;
         nan_q    <= nan_d;
         pinf_q   <= pinf_d;
         e_q      <= e_d;
      end
   end

   assign OUT_DATA = out_q;
   assign RESULT   = result_q;
   assign IS_NAN   = nan_q;
   assign IS_PINF  = pinf_q;
   assign IS_NINF  = 1'b0;

endmodule

// File: tb/tb_fp16_square.sv
// Testbench for fp16_square: directed cases plus random operands checked
// against a real-arithmetic reference model with truncation.
module tb_fp16_square;

   logic        CLK = 1'b0;
   logic        ENABLE = 1'b0;
   logic [15:0] IN_DATA = 16'h0000;
   logic [15:0] OUT_DATA;
   logic        RESULT, IS_NAN, IS_PINF, IS_NINF;

   int n_assert = 0;
   int n_fail   = 0;

   fp16_square dut (
      .CLK      (CLK),
      .ENABLE   (ENABLE),
      .IN_DATA  (IN_DATA),
      .OUT_DATA (OUT_DATA),
      .RESULT   (RESULT),
      .IS_NAN   (IS_NAN),
      .IS_PINF  (IS_PINF),
      .IS_NINF  (IS_NINF)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic real pow2(input int k);
      real r = 1.0;
      if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
      else        for (int i = 0; i < -k; i++) r = r / 2.0;
      return r;
   endfunction

   // Reference: decode to real, square exactly, re-encode with truncation.
   task automatic ref_sq(input logic [15:0] a, output logic [15:0] o,
                         output logic nan, output logic pinf, output int lat);
      int  ex, mn, k, frac, sg;
      real v, sq, x;
      ex = int'(a[14:10]);
      mn = int'(a[9:0]);
      nan = 1'b0; pinf = 1'b0; lat = 13;
      if (ex == 31) begin
         lat = 1;
         if (mn != 0) begin o = a | 16'h0200; nan = 1'b1; end
         else begin o = 16'h7C00; pinf = 1'b1; end
         return;
      end
      if (ex == 0 && mn == 0) begin o = 16'h0000; lat = 1; return; end
      if (ex == 0) v = real'(mn) * pow2(-24);
      else         v = real'(1024 + mn) * pow2(ex - 25);
      sq = v * v;
      if (sq >= 65536.0) begin o = 16'h7C00; pinf = 1'b1; return; end
      x = sq; k = 0;
      while (x >= 2.0) begin x = x / 2.0; k++; end
      while (x < 1.0)  begin x = x * 2.0; k--; end
      if (k >= -14) begin
         frac = int'($floor((x - 1.0) * 1024.0));
         o = {1'b0, 5'(k + 15), 10'(frac)};
      end else begin
         sg = int'($floor(sq * pow2(24)));
         o = 16'(sg);
      end
   endtask

   // Reset, start an operation and count edges until RESULT rises.
   task automatic run_op(input logic [15:0] a, output int lat);
      ENABLE = 1'b0;
      @(posedge CLK); #1;
      IN_DATA = a;
      ENABLE  = 1'b1;
      lat = 0;
      while (1) begin
         @(posedge CLK); #1;
         lat++;
         if (RESULT) break;
         if (lat > 40) begin
            n_assert++; n_fail++;
            $error("FAIL timeout: RESULT never rose for %h", a);
            break;
         end
      end
   endtask

   task automatic check_op(input string tag, input logic [15:0] a, input logic [15:0] eo,
                           input logic en, input logic ep, input int el);
      int lat;
      run_op(a, lat);
      chk({tag, "_out"},  32'(OUT_DATA), 32'(eo));
      chk({tag, "_nan"},  32'(IS_NAN),   32'(en));
      chk({tag, "_pinf"}, 32'(IS_PINF),  32'(ep));
      chk({tag, "_ninf"}, 32'(IS_NINF),  32'd0);
      chk({tag, "_lat"},  32'(lat),      32'(el));
   endtask

   initial begin
      logic [15:0] a, eo, held;
      logic        en, ep;
      int          el;

      // Reset state
      ENABLE = 1'b0;
      @(posedge CLK); @(posedge CLK); #1;
      chk("rst_result", 32'(RESULT),   32'd0);
      chk("rst_out",    32'(OUT_DATA), 32'd0);
      chk("rst_flags",  32'({IS_NAN, IS_PINF, IS_NINF}), 32'd0);

      // Directed cases
      check_op("two",     16'h4000, 16'h4400, 1'b0, 1'b0, 13);
      check_op("onehalf", 16'h3E00, 16'h4080, 1'b0, 1'b0, 13);
      check_op("neg3",    16'hC200, 16'h4880, 1'b0, 1'b0, 13);
      check_op("ovf",     16'h5C00, 16'h7C00, 1'b0, 1'b1, 13);
      check_op("sub_out", 16'h1C00, 16'h0100, 1'b0, 1'b0, 13);
      check_op("tiny",    16'h0001, 16'h0000, 1'b0, 1'b0, 13);
      check_op("max",     16'h7BFF, 16'h7C00, 1'b0, 1'b1, 13);
      check_op("nan",     16'h7C01, 16'h7E01, 1'b1, 1'b0, 1);
      check_op("ninf",    16'hFC00, 16'h7C00, 1'b0, 1'b1, 1);
      check_op("nzero",   16'h8000, 16'h0000, 1'b0, 1'b0, 1);

      // DONE holds against IN_DATA changes
      held = OUT_DATA;
      IN_DATA = 16'h4000;
      repeat (3) @(posedge CLK);
      #1;
      chk("hold_out",    32'(OUT_DATA), 32'h0000);
      chk("hold_result", 32'(RESULT),   32'd1);

      // Abort during MULT (counter 5 executes on edge 7)
      ENABLE = 1'b0;
      @(posedge CLK); #1;
      IN_DATA = 16'h4000;
      ENABLE  = 1'b1;
      repeat (7) @(posedge CLK);
      #1;
      chk("abort_busy", 32'(RESULT), 32'd0);
      ENABLE = 1'b0;
      @(posedge CLK); #1;
      chk("abort_result", 32'(RESULT),   32'd0);
      chk("abort_out",    32'(OUT_DATA), 32'd0);
      check_op("restart", 16'h4000, 16'h4400, 1'b0, 1'b0, 13);

      // Random operands against the reference model
      for (int i = 0; i < 60; i++) begin
         a = 16'($urandom);
         if (i % 4 == 0) a[14:10] = 5'd0;            // bias toward subnormals
         ref_sq(a, eo, en, ep, el);
         check_op($sformatf("rnd%0d_%h", i, a), a, eo, en, ep, el);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
